err_tally: RTL
==============

# err_tally

Downstream error-analysis stage for the bit-flip injector. It compares each N-bit chunk as sent (pre-injection) with the chunk as received (post-injection) and tallies statistics over a fixed window of WINDOW accepted chunks. It reports the results through a valid/ack handshake. Three statistics are kept: total flipped bits, the number of chunks with at least one error, and the worst single-chunk flip count.

## Interface
- N, 3, chunk width; must match the injector's N
- WINDOW, 16, number of accepted chunks per measurement (≥1)
- CW, 16, width of the bit-error and error-chunk counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  pulse: clears counters and begins a window (honoured only in IDLE)
- in_valid  in  1  sent/recv pair valid this cycle
- sent  in  N  original chunk
- recv  in  N  chunk after the injector
- ack  in  1  consumer acknowledges results (honoured only in DONE)
- busy  out  1  high in RUN
- result_valid  out  1  high in DONE
- bit_errs  out  CW  total flipped bits in window, saturating
- err_chunks  out  CW  chunks with popcount(sent^recv) ≠ 0, saturating
- max_flips  out  $clog2(N+1)  largest per-chunk flip count in window

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → clear bit_errs, err_chunks, max_flips and the chunk counter; next state RUN. Outputs otherwise hold their last values.
- RUN: on each cycle with in_valid=1:
  - f = popcount(sent ^ recv)
  - bit_errs += f, saturating at 2^CW−1
  - err_chunks += (f≠0), saturating
  - max_flips = max(max_flips, f)
  - chunk counter += 1
- RUN: in_valid=0 leaves all state unchanged. start is ignored.
- Window end: the cycle that accepts the WINDOW-th chunk updates the counters and moves the FSM to DONE.
- DONE: results are frozen. in_valid and start are ignored. ack=1 → IDLE.
- Simultaneous start and ack in DONE: ack wins; the next state is IDLE and start is dropped.
- Chunk counter width is $clog2(WINDOW+1). It never wraps, because it is cleared on start.
- Reset at any time, including mid-window or in DONE, aborts the window:
  - state IDLE
  - busy=0, result_valid=0
  - bit_errs=0, err_chunks=0, max_flips=0, chunk counter=0

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Accumulation latency: a chunk accepted at edge k is reflected in the outputs after edge k.
- start at edge k → busy=1 from edge k.
- WINDOW-th chunk accepted at edge k → busy=0 and result_valid=1 from edge k.
- ack at edge k → result_valid=0 from edge k. The earliest subsequent start is honoured at edge k+1.
- Minimum window duration is WINDOW cycles with back-to-back in_valid. There is no maximum; the block waits indefinitely for in_valid.
- Throughput: one chunk per clock, no backpressure. The upstream injector is free-running.

## Structure
- Shared package err_pkg:
  - state enum {IDLE, RUN, DONE}
  - a localparam helper for the $clog2 widths, used by both injector and tally
- Sub-module popcount #(N): purely combinational count of ones in an N-bit vector, producing a $clog2(N+1)-bit result. It is instantiated once on sent^recv.
- The FSM, saturating adders and max register live in err_tally.

## Test plan
- Reset, then idle 5 cycles → all outputs 0. in_valid pulses in IDLE → no change.
- N=3, WINDOW=4: start, then pairs (sent,recv) = (000,000), (101,100), (111,000), (010,011) on consecutive cycles → bit_errs=5, err_chunks=3, max_flips=3. result_valid rises on the 4th accept edge. ack clears result_valid and the values hold.
- Gaps: same 4 pairs with in_valid low for 2 cycles between each → identical results; busy stays high throughout.
- Saturation: CW=3, WINDOW=4, all pairs (000,111) → bit_errs=7 (saturated), err_chunks=4 (wrap to 4 is within range), max_flips=3.
- Reset mid-window after 2 accepted chunks → all outputs 0, state IDLE. The next start runs a full clean window.
- start and ack asserted together in DONE → IDLE with result_valid=0 and busy=0. start in RUN ignored, so counters are not cleared.

Source files
------------

// File: rtl/err_pkg.sv
// Shared types and width helpers for the bit-flip injector and error tally.
package err_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/err_tally_popcount.sv
// Combinational count of ones in an N-bit vector.
module popcount
  import err_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        vec,
  output logic [cnt_w(N)-1:0] cnt
);

  localparam int PW = cnt_w(N);

  // Straight adder chain; N is small, so depth is not a concern.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + PW'(vec[i]);
  end

endmodule

// File: rtl/err_tally.sv
// Error tally: compares sent/received chunks over a window of accepted
// chunks and reports total flipped bits, errored chunks and worst chunk.
module err_tally
  import err_pkg::*;
#(
  parameter int N      = 3,
  parameter int WINDOW = 16,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [N-1:0]        sent,
  input  logic [N-1:0]        recv,
  input  logic                ack,
  output logic                busy,
  output logic                result_valid,
  output logic [CW-1:0]       bit_errs,
  output logic [CW-1:0]       err_chunks,
  output logic [cnt_w(N)-1:0] max_flips
);

  localparam int FW = cnt_w(N);
  localparam int KW = cnt_w(WINDOW);

  state_t        state, state_nxt;
  logic [KW-1:0] chunk_cnt;
  logic [FW-1:0] flips;
  logic          accept, last;
  logic [CW:0]   be_sum, ec_sum;

  popcount #(.N(N)) u_pc (.vec(sent ^ recv), .cnt(flips));

  assign accept = (state == RUN) && in_valid;
  assign last   = accept && (chunk_cnt == KW'(WINDOW - 1));

  // One extra bit catches the carry out for saturation.
  assign be_sum = {1'b0, bit_errs}   + (CW+1)'(flips);
  assign ec_sum = {1'b0, err_chunks} + (CW+1)'(flips != '0);

  // Flags decode the state register only, so outputs stay registered.
  assign busy         = (state == RUN);
  assign result_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: start only from IDLE, ack only from DONE (ack beats start).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Statistics: cleared on start, updated on every accepted chunk.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      bit_errs   <= '0;
      err_chunks <= '0;
      max_flips  <= '0;
      chunk_cnt  <= '0;
    end else if (accept) begin
      bit_errs   <= be_sum[CW] ? {CW{1'b1}} : be_sum[CW-1:0];
      err_chunks <= ec_sum[CW] ? {CW{1'b1}} : ec_sum[CW-1:0];
      if (flips > max_flips) max_flips <= flips;
      chunk_cnt  <= chunk_cnt + KW'(1);
    end
  end

endmodule
